rca_writeback_buffer: RTL and testbench
=======================================

// Module: rca_writeback_buffer
// PURPOSE
//  Elastic result buffer between the RCA (reconfigurable custom accelerator) datapath and
//  register_file_and_writeback. Accepts one multi-result RCA completion per cycle: an ID plus
//  NUM_WRITE_PORTS data words. Stores it in a small in-order FIFO and presents the oldest entry
//  on the rca_wb interface (done/id/rd) until the writeback stage acks it.
//  Decouples RCA completion timing from regfile commit and absorbs ack back-pressure.
// PARAMETERS
//  NUM_WRITE_PORTS  2   results per RCA completion (matches RCA regfile write ports)
//  DEPTH            4   FIFO entries; power of two, >=2
//  XLEN             32  data word width (taiga_config)
//  ID_W             $bits(id_t)  instruction ID width
// PORTS
//  clk              in   1                 clock, all state on rising edge
//  rst              in   1                 asynchronous, active-low reset
//  gc_flush         in   1                 synchronous flush of all buffered entries
//  res_valid        in   1                 RCA presents a completion this cycle
//  res_ready        out  1                 buffer can accept (registered, = ~full)
//  res_id           in   ID_W              ID of the completing RCA instruction
//  res_data         in   XLEN x NUM_WRITE_PORTS  result words, port order preserved
//  wb_done          out  1                 head entry valid (drives rca_wb.done)
//  wb_id            out  ID_W              head entry ID (rca_wb.id)
//  wb_rd            out  XLEN x NUM_WRITE_PORTS  head entry data (rca_wb.rd)
//  wb_ack           in   1                 writeback consumed head (rca_wb.ack)
//  occupancy        out  $clog2(DEPTH)+1   current entry count
//  overflow_err     out  1                 sticky: res_valid seen while res_ready low
// BEHAVIOUR
//  - Reset (rst==0, async): rd/wr ptrs=0, occupancy=0, wb_done=0, res_ready=1,
//    overflow_err=0. wb_id/wb_rd=0. Storage array not reset.
//  - push = res_valid & res_ready. pop = wb_ack & wb_done. wb_ack with wb_done=0 is ignored.
//  - Latency: push in cycle N -> wb_done=1 with that entry in cycle N+1 (no comb bypass
//    from res_* to wb_*).
//  - Outputs wb_done/wb_id/wb_rd are registered head values; after pop in cycle N the next
//    entry (if any) is visible in N+1. Back-to-back acks drain one entry per cycle.
//  - Ordering strictly FIFO; entries never reordered, merged or dropped except by gc_flush.
//  - occupancy' = occupancy + push - pop; push&pop together keep count, advance both ptrs.
//  - Full (occupancy==DEPTH): res_ready=0 registered, so simultaneous pop does NOT admit a push
//    that cycle; ready returns the cycle after the pop.
//  - Empty: wb_done=0; push and pop cannot coincide on same entry (pop needs wb_done).
//  - Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH; full/empty from occupancy.
//  - res_valid while res_ready=0: data discarded, overflow_err set; only rst clears it.
//  - gc_flush: next cycle ptrs=0, occupancy=0, wb_done=0, res_ready=1. Overrides
//    push/pop in the same cycle. overflow_err unaffected.
//  - Async reset mid-operation: immediate return to reset state, buffered entries lost.
// STRUCTURE
//  - id_t, XLEN, NUM_WRITE_PORTS come from taiga_config/taiga_types. Add a packed
//    rca_wb_entry_t {id_t id; logic [XLEN-1:0] rd [NUM_WRITE_PORTS];} to taiga_types.
//  - Single module; storage as array of rca_wb_entry_t (LUTRAM-inferable), ptr/count regs,
//    registered head stage. No sub-module needed.
// TESTING
//  1 Reset then single push id=3, data={0xDEADBEEF,0x12345678} -> wb_done=1 next cycle,
//    wb_id=3, wb_rd matches; ack -> wb_done=0 following cycle, occupancy=0.
//  2 Push ids 1,2,3,4 back-to-back, no ack -> res_ready=0 after 4th, occupancy=4; 5th
//    res_valid -> overflow_err=1, entry dropped; ack x4 -> ids pop 1,2,3,4 in order.
//  3 Steady stream: push+ack every cycle for 20 cycles -> occupancy stays 1, ids in order,
//    no bubbles after first.
//  4 Full buffer, push and ack same cycle -> push refused (res_ready=0), occupancy=3,
//    res_ready=1 next cycle.
//  5 3 entries buffered, gc_flush with res_valid and wb_ack high -> next cycle occupancy=0,
//    wb_done=0, res_ready=1; subsequent push id=7 appears as head.
//  6 Assert rst mid-stream (2 entries, between clock edges) -> outputs reset values
//    immediately, no phantom wb_done after release.

Source files
------------

// File: rtl/rca_writeback_buffer_pkg.sv
// Shared types and sizing for the RCA writeback buffer.
package rca_writeback_buffer_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned NUM_WRITE_PORTS = 2;
    localparam int unsigned MAX_IDS         = 8;
    localparam int unsigned ID_W            = $clog2(MAX_IDS);

    typedef logic [ID_W-1:0] id_t;

    // One RCA completion: instruction ID plus one word per regfile write port.
    typedef struct packed {
        id_t                                   id;
        logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  rd;
    } rca_wb_entry_t;

endpackage

// File: rtl/rca_writeback_buffer.sv
// In-order elastic buffer between RCA completions and regfile writeback.
// Head entry is presented from a registered stage; no combinational path from res_* to wb_*.
module rca_writeback_buffer
    import rca_writeback_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            gc_flush,
    input  logic                            res_valid,
    output logic                            res_ready,
    input  logic [ID_W-1:0]                 res_id,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0] res_data,
    output logic                            wb_done,
    output logic [ID_W-1:0]                 wb_id,
    output logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd,
    input  logic                            wb_ack,
    output logic [$clog2(DEPTH):0]          occupancy,
    output logic                            overflow_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    rca_wb_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ready;
    logic             r_done;
    logic             r_ovf;
    rca_wb_entry_t    r_head;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    rca_wb_entry_t    w_in_entry;
    rca_wb_entry_t    w_head_nxt;

    assign w_push        = res_valid & r_ready;
    assign w_pop         = wb_ack & r_done;
    assign w_in_entry.id = res_id;
    assign w_in_entry.rd = res_data;

    // Next pointer/count state; flush overrides any push or pop.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (gc_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // The slot becoming head may be the one being written this cycle.
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
        if (w_push && !gc_flush && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = w_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !gc_flush) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_ready  <= (w_count_nxt != CNT_W'(DEPTH));
            r_done   <= (w_count_nxt != '0);
            if (res_valid && !r_ready) begin
                r_ovf <= 1'b1;
            end
            if (w_count_nxt != '0) begin
                r_head <= w_head_nxt;
            end
        end
    end

    assign res_ready    = r_ready;
    assign wb_done      = r_done;
    assign wb_id        = r_head.id;
    assign wb_rd        = r_head.rd;
    assign occupancy    = r_count;
    assign overflow_err = r_ovf;

endmodule

// File: tb/tb_rca_writeback_buffer.sv
// Scenario bench for rca_writeback_buffer with a scoreboard of expected head entries.
module tb_rca_writeback_buffer;

    typedef struct {
        logic [2:0]  id;
        logic [63:0] rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        gc_flush;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_id;
    logic [63:0] res_data;
    logic        wb_done;
    logic [2:0]  wb_id;
    logic [63:0] wb_rd;
    logic        wb_ack;
    logic [2:0]  occupancy;
    logic        overflow_err;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rca_writeback_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .gc_flush     (gc_flush),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_id       (res_id),
        .res_data     (res_data),
        .wb_done      (wb_done),
        .wb_id        (wb_id),
        .wb_rd        (wb_rd),
        .wb_ack       (wb_ack),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; outputs are stable when this returns.
    task automatic step(input logic v, input logic [2:0] id, input logic [63:0] d,
                        input logic ack, input logic fl);
        res_valid = v;
        res_id    = id;
        res_data  = d;
        wb_ack    = ack;
        gc_flush  = fl;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        wb_ack    = 1'b0;
        gc_flush  = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] id, input logic [63:0] d);
        exp_t e;
        e.id = id;
        e.rd = d;
        sb.push_back(e);
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            e.id = '0;
            e.rd = '0;
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_underflow got empty want entry");
        end else begin
            e = sb.pop_front();
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b0; gc_flush = 1'b0; res_valid = 1'b0; res_id = '0; res_data = '0; wb_ack = 1'b0;
        #12;
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", res_ready); end
        n_cmp++; if (wb_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", wb_done); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow_err); end
        n_cmp++; if ({wb_id, wb_rd} !== 67'd0) begin n_err++; $display("FAIL reset_head got %0h/%0h want 0/0", wb_id, wb_rd); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        exp_t e;
        logic [63:0] d;
        d = {32'h12345678, 32'hDEADBEEF};
        push_exp(3'd3, d);
        res_valid = 1'b1; res_id = 3'd3; res_data = d;
        #1;
        n_cmp++; if (wb_done !== 1'b0) begin n_err++; $display("FAIL single_no_bypass got %0b want 0", wb_done); end
        step(1'b1, 3'd3, d, 1'b0, 1'b0);
        pop_exp(e);
        n_cmp++; if (wb_done !== 1'b1) begin n_err++; $display("FAIL single_done got %0b want 1", wb_done); end
        n_cmp++; if ({wb_id, wb_rd} !== {e.id, e.rd}) begin n_err++; $display("FAIL single_head got %0d/%0h want %0d/%0h", wb_id, wb_rd, e.id, e.rd); end
        n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL single_occ got %0d want 1", occupancy); end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        n_cmp++; if (wb_done !== 1'b0) begin n_err++; $display("FAIL single_drain_done got %0b want 0", wb_done); end
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL single_drain_occ got %0d want 0", occupancy); end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL single_stray_ack got %0d want 0", occupancy); end
    endtask

    task automatic test_fill_overflow();
        exp_t e;
        logic [63:0] d;
        for (int i = 1; i <= 4; i++) begin
            d = rnd64();
            push_exp(3'(i), d);
            step(1'b1, 3'(i), d, 1'b0, 1'b0);
        end
        n_cmp++; if (res_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %0b want 0", res_ready); end
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL fill_occ got %0d want 4", occupancy); end
        n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL fill_ovf_early got %0b want 0", overflow_err); end
        step(1'b1, 3'd5, rnd64(), 1'b0, 1'b0);
        n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL fill_ovf got %0b want 1", overflow_err); end
        n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL fill_drop_occ got %0d want 4", occupancy); end
        for (int i = 0; i < 4; i++) begin
            pop_exp(e);
            n_cmp++; if (wb_done !== 1'b1) begin n_err++; $display("FAIL fill_pop_done[%0d] got %0b want 1", i, wb_done); end
            n_cmp++; if ({wb_id, wb_rd} !== {e.id, e.rd}) begin n_err++; $display("FAIL fill_pop_head[%0d] got %0d/%0h want %0d/%0h", i, wb_id, wb_rd, e.id, e.rd); end
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (wb_done !== 1'b0) begin n_err++; $display("FAIL fill_empty_done got %0b want 0", wb_done); end
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL fill_empty_ready got %0b want 1", res_ready); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [63:0] d;
        d = rnd64();
        push_exp(3'd0, d);
        step(1'b1, 3'd0, d, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            pop_exp(e);
            n_cmp++; if (wb_done !== 1'b1) begin n_err++; $display("FAIL stream_done[%0d] got %0b want 1", i, wb_done); end
            n_cmp++; if ({wb_id, wb_rd} !== {e.id, e.rd}) begin n_err++; $display("FAIL stream_head[%0d] got %0d/%0h want %0d/%0h", i, wb_id, wb_rd, e.id, e.rd); end
            d = rnd64();
            push_exp(3'(i), d);
            step(1'b1, 3'(i), d, 1'b1, 1'b0);
            n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
        end
        pop_exp(e);
        n_cmp++; if ({wb_id, wb_rd} !== {e.id, e.rd}) begin n_err++; $display("FAIL stream_last got %0d/%0h want %0d/%0h", wb_id, wb_rd, e.id, e.rd); end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        n_cmp++; if (wb_done !== 1'b0) begin n_err++; $display("FAIL stream_drain got %0b want 0", wb_done); end
    endtask

    task automatic test_full_push_ack();
        exp_t e;
        logic [63:0] d;
        for (int i = 0; i < 4; i++) begin
            d = rnd64();
            push_exp(3'(i), d);
            step(1'b1, 3'(i), d, 1'b0, 1'b0);
        end
        pop_exp(e);
        n_cmp++; if ({wb_id, wb_rd} !== {e.id, e.rd}) begin n_err++; $display("FAIL full_head got %0d/%0h want %0d/%0h", wb_id, wb_rd, e.id, e.rd); end
        step(1'b1, 3'd4, rnd64(), 1'b1, 1'b0);
        n_cmp++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL full_pa_occ got %0d want 3", occupancy); end
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL full_pa_ready got %0b want 1", res_ready); end
        for (int i = 0; i < 3; i++) begin
            pop_exp(e);
            n_cmp++; if ({wb_done, wb_id, wb_rd} !== {1'b1, e.id, e.rd}) begin n_err++; $display("FAIL full_drain[%0d] got %0b/%0d/%0h want 1/%0d/%0h", i, wb_done, wb_id, wb_rd, e.id, e.rd); end
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (wb_done !== 1'b0) begin n_err++; $display("FAIL full_empty got %0b want 0", wb_done); end
    endtask

    task automatic test_flush();
        exp_t e;
        logic [63:0] d;
        for (int i = 1; i <= 3; i++) begin
            d = rnd64();
            push_exp(3'(i), d);
            step(1'b1, 3'(i), d, 1'b0, 1'b0);
        end
        step(1'b1, 3'd5, rnd64(), 1'b1, 1'b1);
        sb.delete();
        n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        n_cmp++; if (wb_done !== 1'b0) begin n_err++; $display("FAIL flush_done got %0b want 0", wb_done); end
        n_cmp++; if (res_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got %0b want 1", res_ready); end
        d = rnd64();
        push_exp(3'd7, d);
        step(1'b1, 3'd7, d, 1'b0, 1'b0);
        pop_exp(e);
        n_cmp++; if ({wb_done, wb_id, wb_rd} !== {1'b1, e.id, e.rd}) begin n_err++; $display("FAIL flush_after got %0b/%0d/%0h want 1/%0d/%0h", wb_done, wb_id, wb_rd, e.id, e.rd); end
        n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL flush_after_occ got %0d want 1", occupancy); end
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 3'(i + 2), rnd64(), 1'b0, 1'b0);
        end
        n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL arst_pre_occ got %0d want 2", occupancy); end
        #3;
        rst = 1'b0;
        #1;
        n_cmp++; if ({wb_done, res_ready, occupancy, overflow_err} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
            n_err++; $display("FAIL arst_state got done=%0b rdy=%0b occ=%0d ovf=%0b want 0/1/0/0", wb_done, res_ready, occupancy, overflow_err);
        end
        n_cmp++; if ({wb_id, wb_rd} !== 67'd0) begin n_err++; $display("FAIL arst_head got %0d/%0h want 0/0", wb_id, wb_rd); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0);
            n_cmp++; if ({wb_done, occupancy} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL arst_phantom[%0d] got done=%0b occ=%0d want 0/0", i, wb_done, occupancy); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_full_push_ack();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
